muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit sitting beside the single-cycle ALU in the execute stage.
//  Accepts one operation on a start/ready handshake, computes MUL/MULH*/DIV*/REM* and their W variants,
//  and returns a registered XLEN result with a one-cycle done pulse. Flags illegal encodings itself.
// PARAMETERS
//  XLEN  64  datapath width; legal values 32 or 64 (W ops legal only when XLEN==64)
// PORTS
//  i_clk            in   1     clock, all state updates on rising edge
//  i_rst            in   1     synchronous, active-high reset
//  i_start          in   1     request; accepted only while o_ready==1
//  o_ready          out  1     unit idle, can accept i_start
//  i_func_3         in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  i_word           in   1     1 = W variant (32-bit op, result sign-extended to XLEN)
//  i_src_1          in   XLEN  rs1 / dividend / multiplicand
//  i_src_2          in   XLEN  rs2 / divisor / multiplier
//  i_flush          in   1     abort in-flight op (pipeline kill)
//  o_done           out  1     one-cycle pulse; o_result/o_illegal_instr valid in this cycle
//  o_result         out  XLEN  registered result, held until the next o_done
//  o_illegal_instr  out  1     registered; valid with o_done
// BEHAVIOUR
//  - Reset: state IDLE, o_ready=1, o_done=0, o_result=0, o_illegal_instr=0, counter=0.
//  - States: IDLE, PREP, CALC, FIX, DONE. o_ready=1 only in IDLE; o_done=1 only in DONE.
//  - IDLE: i_start=1 latches func_3, word, operands (cycle 0). Illegal (i_word=1 with func_3 in
//    {001,010,011}, or i_word=1 with XLEN==32) -> DONE with result 0, illegal=1 (o_done in cycle 1).
//    Otherwise -> PREP.
//  - PREP: W ops take low 32 bits (sign- or zero-extended per op); signed ops take absolute values,
//    record result sign. Special cases go straight to DONE (o_done in cycle 2):
//    div by zero: quotient = all ones (W: 0xFFFF_FFFF sign-extended), remainder = dividend;
//    signed overflow (MIN / -1): quotient = MIN, remainder = 0. Else counter=N, -> CALC.
//  - CALC: N iterations, N = XLEN (or 32 if W). Multiply: radix-2 shift-add into 2N-bit product.
//    Divide: radix-2 restoring, one quotient bit per cycle. counter decrements; at 1 -> FIX.
//  - FIX: apply sign (two's-complement negate); MUL* selects low N (MUL) or high N (MULH*) bits;
//    REM sign follows dividend, DIV sign = sign1 XOR sign2; W result sign-extended bit 31. -> DONE.
//  - DONE: o_done=1 for exactly one cycle, result registered; -> IDLE. Normal latency: o_done in
//    cycle N+3 (XLEN=64: 67, W: 35). i_start during DONE is ignored (o_ready=0).
//  - i_start outside IDLE ignored; operand changes after acceptance have no effect.
//  - i_flush: any state -> IDLE next cycle, no o_done, o_result keeps previous value; i_flush and
//    i_start together in IDLE: flush wins, nothing accepted.
//  - i_rst mid-operation: same as reset values, o_result cleared to 0.
//  - All arithmetic modulo 2^XLEN; no exceptions raised besides o_illegal_instr.
// STRUCTURE
//  - muldiv_pkg: state enum t_muldiv_state, func_3 localparams (F3_MUL..F3_REMU), helper function
//    sext32(). Shared with the ALU decoder for consistent opcode naming.
//  - One sub-module natural: muldiv_operand_prep (combinational; W truncation/extension, abs value,
//    sign flags, special-case detect). FSM, counter and shift/accumulate datapath stay in top.
// TESTING
//  1. XLEN=64, MUL 7 * -3 -> o_done in cycle 67, o_result=0xFFFF_FFFF_FFFF_FFEB, illegal=0.
//  2. MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> o_result=0x1; MULHSU -1 * 2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. DIV 100 / 0 -> o_done in cycle 2, o_result=all ones; REM 100 / 0 -> 100.
//  4. DIVW 0x8000_0000 / 0xFFFF_FFFF -> o_result=0xFFFF_FFFF_8000_0000 (cycle 2); REMW same -> 0.
//  5. func_3=001 with i_word=1 -> o_done in cycle 1, o_illegal_instr=1, o_result=0.
//  6. DIVU start, i_flush at cycle 10 -> IDLE at cycle 11, no o_done, o_ready=1; new REM -7/2 -> -1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, func_3 opcode names and helpers for the RV32M/RV64M unit
package muldiv_pkg;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} t_muldiv_state;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: W truncation/extension, magnitudes, sign flags and divide special-case detect
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      func_3,
    input  logic            word,
    input  logic [XLEN-1:0] src_1,
    input  logic [XLEN-1:0] src_2,
    output logic [XLEN-1:0] ext_1,
    output logic [XLEN-1:0] mag_1,
    output logic [XLEN-1:0] mag_2,
    output logic            sign_1,
    output logic            sign_2,
    output logic            div_zero,
    output logic            overflow
);

    logic            signed_1;
    logic            signed_2;
    logic [XLEN-1:0] ext_2;
    logic [XLEN-1:0] min_val;
    logic [63:0]     s1;
    logic [63:0]     s2;

    always_comb begin
        signed_1 = func_3 != F3_MULHU && func_3 != F3_DIVU && func_3 != F3_REMU;
        signed_2 = signed_1 && func_3 != F3_MULHSU;
        s1       = sext32(src_1[31:0]);
        s2       = sext32(src_2[31:0]);
        ext_1    = !word ? src_1 : signed_1 ? s1[XLEN-1:0] : XLEN'(src_1[31:0]);
        ext_2    = !word ? src_2 : signed_2 ? s2[XLEN-1:0] : XLEN'(src_2[31:0]);
        sign_1   = signed_1 && ext_1[XLEN-1];
        sign_2   = signed_2 && ext_2[XLEN-1];
        mag_1    = sign_1 ? -ext_1 : ext_1;
        mag_2    = sign_2 ? -ext_2 : ext_2;
        // most negative value of the operation width, already extended to XLEN
        min_val  = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = func_3[2] && ext_2 == '0;
        overflow = func_3[2] && signed_1 && !div_zero && ext_1 == min_val && ext_2 == '1;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with start/ready handshake and done pulse
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_ready,
    input  logic [2:0]      i_func_3,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_src_1,
    input  logic [XLEN-1:0] i_src_2,
    input  logic            i_flush,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal_instr
);

    localparam int CW = $clog2(XLEN + 1);

    t_muldiv_state     state, state_nxt;
    logic [2:0]        func_q;
    logic              word_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   ext_1, mag_1, mag_2;
    logic              sign_1, sign_2, div_zero, overflow;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   sh, dvs;
    logic [CW-1:0]     cnt;
    logic              illegal, is_div, special, ge;
    logic [XLEN:0]     rem_try;
    logic [XLEN-1:0]   rem_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q_s, r_s, fix_raw, spec_raw, res_fix, res_spec;
    logic [63:0]       t_fix, t_spec;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .func_3   (func_q),
        .word     (word_q),
        .src_1    (a_q),
        .src_2    (b_q),
        .ext_1    (ext_1),
        .mag_1    (mag_1),
        .mag_2    (mag_2),
        .sign_1   (sign_1),
        .sign_2   (sign_2),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    assign o_ready = state == S_IDLE;
    assign o_done  = state == S_DONE;

    always_comb begin
        illegal  = i_word && (XLEN == 32 || (i_func_3 != F3_MUL && !i_func_3[2]));
        is_div   = func_q[2];
        special  = is_div && (div_zero || overflow);
        // divide: remainder in acc high half, quotient shifts into acc low half
        rem_try  = {acc[2*XLEN-1:XLEN], sh[XLEN-1]};
        ge       = rem_try >= {1'b0, dvs};
        rem_nxt  = ge ? XLEN'(rem_try - {1'b0, dvs}) : rem_try[XLEN-1:0];
        prod     = (sign_1 ^ sign_2) ? -acc : acc;
        q_s      = (sign_1 ^ sign_2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_s      = sign_1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_raw  = is_div ? (func_q[1] ? r_s : q_s)
                          : (func_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        spec_raw = div_zero ? (func_q[1] ? ext_1 : '1) : (func_q[1] ? '0 : ext_1);
        t_fix    = sext32(fix_raw[31:0]);
        t_spec   = sext32(spec_raw[31:0]);
        res_fix  = word_q ? t_fix[XLEN-1:0] : fix_raw;
        res_spec = word_q ? t_spec[XLEN-1:0] : spec_raw;
    end

    always_comb begin
        state_nxt = state;
        if (i_flush)
            state_nxt = S_IDLE;
        else
            case (state)
                S_IDLE:  state_nxt = i_start ? (illegal ? S_DONE : S_PREP) : S_IDLE;
                S_PREP:  state_nxt = special ? S_DONE : S_CALC;
                S_CALC:  state_nxt = cnt == CW'(1) ? S_FIX : S_CALC;
                S_FIX:   state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            func_q          <= '0;
            word_q          <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            acc             <= '0;
            sh              <= '0;
            dvs             <= '0;
            cnt             <= '0;
            o_result        <= '0;
            o_illegal_instr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_start && !i_flush) begin
                    func_q          <= i_func_3;
                    word_q          <= i_word;
                    a_q             <= i_src_1;
                    b_q             <= i_src_2;
                    o_illegal_instr <= illegal;
                    if (illegal)
                        o_result <= '0;
                end
                S_PREP: begin
                    // operands are consumed MSB-first; W operands are left-aligned
                    acc <= '0;
                    dvs <= is_div ? mag_2 : mag_1;
                    sh  <= word_q ? (is_div ? mag_1 : mag_2) << (XLEN - 32) : (is_div ? mag_1 : mag_2);
                    cnt <= word_q ? CW'(32) : CW'(XLEN);
                    if (special && !i_flush) begin
                        o_result        <= res_spec;
                        o_illegal_instr <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? {rem_nxt, acc[XLEN-2:0], ge}
                                  : {acc[2*XLEN-2:0], 1'b0} + (sh[XLEN-1] ? {{XLEN{1'b0}}, dvs} : '0);
                    sh  <= sh << 1;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: if (!i_flush) begin
                    o_result        <= res_fix;
                    o_illegal_instr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a wide-arithmetic reference model
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_ready;
    logic [2:0]  i_func_3 = '0;
    logic        i_word = 1'b0;
    logic [63:0] i_src_1 = '0;
    logic [63:0] i_src_2 = '0;
    logic        i_flush = 1'b0;
    logic        o_done;
    logic [63:0] o_result;
    logic        o_illegal_instr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_res = '0;

    always #5 i_clk = ~i_clk;

    muldiv_unit #(.XLEN(64)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .o_ready         (o_ready),
        .i_func_3        (i_func_3),
        .i_word          (i_word),
        .i_src_1         (i_src_1),
        .i_src_2         (i_src_2),
        .i_flush         (i_flush),
        .o_done          (o_done),
        .o_result        (o_result),
        .o_illegal_instr (o_illegal_instr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: exact 128-bit signed arithmetic, then truncate to the architectural width
    function automatic void ref_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                                   input logic [63:0] b, output logic [63:0] res,
                                   output logic ill, output int lat);
        logic signed [127:0] aa, bb, pp, qq, rr, mn;
        logic [63:0] v;
        logic sa, sb;
        int n;
        ill = w && (f == 3'd1 || f == 3'd2 || f == 3'd3);
        res = '0;
        lat = 1;
        if (ill) return;
        n  = w ? 32 : 64;
        sa = !(f == 3'd3 || f == 3'd5 || f == 3'd7);
        sb = sa && f != 3'd2;
        aa = w ? (sa ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]}) : (sa ? {{64{a[63]}}, a} : {64'b0, a});
        bb = w ? (sb ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]}) : (sb ? {{64{b[63]}}, b} : {64'b0, b});
        mn = -(128'sd1 <<< (n - 1));
        lat = n + 3;
        if (!f[2]) begin
            pp = aa * bb;
            v  = (f == 3'd0 || w) ? pp[63:0] : pp[127:64];
        end else begin
            if (bb == 0) begin
                qq  = -128'sd1;
                rr  = aa;
                lat = 2;
            end else begin
                qq = aa / bb;
                rr = aa % bb;
                if (sa && bb == -128'sd1 && aa == mn) lat = 2;
            end
            v = f[1] ? rr[63:0] : qq[63:0];
        end
        res = w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic ei;
        int el, cyc;
        ref_op(f, w, a, b, er, ei, el);
        @(negedge i_clk);
        i_start = 1'b1; i_func_3 = f; i_word = w; i_src_1 = a; i_src_2 = b;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
        i_src_1  = {$urandom, $urandom};
        i_src_2  = {$urandom, $urandom};
        i_func_3 = 3'($urandom);
        cyc = 1;
        check({tag, " busy"}, {63'b0, o_ready}, 64'd0);
        while (!o_done && cyc < 200) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(el));
        check({tag, " result"}, o_result, er);
        check({tag, " illegal"}, {63'b0, o_illegal_instr}, {63'b0, ei});
        if (o_done) last_res = o_result;
        @(posedge i_clk); #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 40)) - 64'd20;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int cyc, seen;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("reset ready", {63'b0, o_ready}, 64'd1);
        check("reset done", {63'b0, o_done}, 64'd0);
        check("reset result", o_result, 64'd0);
        check("reset illegal", {63'b0, o_illegal_instr}, 64'd0);

        run_op("mul 7*-3", 3'd0, 1'b0, 64'd7, -64'sd3);
        run_op("mulhu", 3'd3, 1'b0, '1, 64'd2);
        run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2);
        run_op("div by 0", 3'd4, 1'b0, 64'd100, 64'd0);
        run_op("rem by 0", 3'd6, 1'b0, 64'd100, 64'd0);
        run_op("divw ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("remw ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op("mulw", 3'd0, 1'b1, 64'h1234_0000_7FFF_FFFF, 64'd2);

        run_op("divu pre", 3'd5, 1'b0, 64'd1000, 64'd7);
        @(negedge i_clk);
        i_start = 1'b1; i_func_3 = 3'd5; i_word = 1'b0; i_src_1 = 64'd5000; i_src_2 = 64'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        cyc = 1;
        seen = 0;
        while (cyc < 10) begin
            @(posedge i_clk); #1;
            cyc++;
            seen += int'(o_done);
        end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush ready", {63'b0, o_ready}, 64'd1);
        check("flush result held", o_result, last_res);
        repeat (70) begin
            @(posedge i_clk); #1;
            seen += int'(o_done);
        end
        check("flush no done", 64'(seen), 64'd0);
        run_op("rem -7/2", 3'd6, 1'b0, -64'sd7, 64'd2);

        @(negedge i_clk);
        i_start = 1'b1; i_flush = 1'b1; i_func_3 = 3'd0; i_src_1 = 64'd3; i_src_2 = 64'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        check("flush+start ready", {63'b0, o_ready}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(posedge i_clk); #1;
            seen += int'(o_done);
        end
        check("flush+start no done", 64'(seen), 64'd0);

        run_op("mulh illegal w", 3'd1, 1'b1, 64'd5, 64'd6);
        run_op("mulw", 3'd0, 1'b1, 64'd9, 64'd9);

        @(negedge i_clk);
        i_start = 1'b1; i_func_3 = 3'd0; i_word = 1'b0; i_src_1 = 64'd11; i_src_2 = 64'd13;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("midrst ready", {63'b0, o_ready}, 64'd1);
        check("midrst result", o_result, 64'd0);
        check("midrst done", {63'b0, o_done}, 64'd0);

        for (int i = 0; i < 40; i++)
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
